// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: two-entry skid buffer between the execute and memory stages
module ex_mem_skid_reg #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [RD_W-1:0]   rd_addr,
    input  logic [4:0]        ctrl_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic              out_zero,
    output logic [RD_W-1:0]   out_rd_addr,
    output logic [4:0]        out_ctrl,
    output logic              out_branch_taken,
    output logic [1:0]        out_count
);
    localparam int EW = 2*DATA_W + RD_W + 6;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t        r_state, w_next;
    logic [EW-1:0] r_head, r_skid, w_in;
    logic          r_in_ready, w_push, w_pop, w_load_head, w_load_skid, w_skid_to_head;
    assign w_in      = {ctrl_in, rd_addr, alu_zero, rs2_data, alu_result};
    assign in_ready  = r_in_ready;
    assign out_valid = r_state != EMPTY;
    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_count = r_state == FULL ? 2'd2 : r_state == ONE ? 2'd1 : 2'd0;
    assign out_alu_result   = r_head[DATA_W-1:0];
    assign out_rs2_data     = r_head[2*DATA_W-1:DATA_W];
    assign out_zero         = r_head[2*DATA_W];
    assign out_rd_addr      = r_head[2*DATA_W+1 +: RD_W];
    assign out_ctrl         = out_valid ? r_head[EW-1 -: 5] : 5'd0;
    assign out_branch_taken = out_ctrl[4] & out_zero;
    // next state and register load selects; flush overrides any push or pop
    always_comb begin
        w_next         = r_state;
        w_load_head    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_head = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    w_next      = w_push ? ONE : EMPTY;
                    w_load_head = w_push;
                end
                ONE: begin
                    w_next      = w_push && !w_pop ? FULL : !w_push && w_pop ? EMPTY : ONE;
                    w_load_head = w_push && w_pop;
                    w_load_skid = w_push && !w_pop;
                end
                FULL: begin
                    w_next         = w_pop ? ONE : FULL;
                    w_skid_to_head = w_pop;
                end
                default: w_next = EMPTY;
            endcase
        end
    end
    // state register; in_ready is registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_next != FULL;
        end
    end
    // head and skid entry storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head)
                r_head <= w_in;
            else if (w_skid_to_head)
                r_head <= r_skid;
            if (w_load_skid)
                r_skid <= w_in;
        end
    end
endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the ALU result and store-data width.
REQ-002 Parameter RD_W, default 5, SHALL set the destination register address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag a valid execute-stage result.
REQ-006 in_ready  output  1  SHALL flag that the block can accept an entry this cycle.
REQ-007 alu_result  input  DATA_W  SHALL carry the 64-bit ALU Result.
REQ-008 alu_zero  input  1  SHALL carry the ALU Zero flag.
REQ-009 rs2_data  input  DATA_W  SHALL carry the store data.
REQ-010 rd_addr  input  RD_W  SHALL carry the destination register.
REQ-011 ctrl_in  input  5  SHALL carry control bits: [0] regwrite, [1] memread, [2] memwrite, [3] memtoreg, [4] branch.
REQ-012 flush  input  1  SHALL synchronously discard all held entries.
REQ-013 out_valid  output  1  SHALL flag a valid entry on the out_* bus.
REQ-014 out_ready  input  1  SHALL flag that the memory stage consumes the entry this cycle.
REQ-015 out_alu_result, out_rs2_data  output  DATA_W each  SHALL present the head entry's data fields.
REQ-016 out_zero, out_rd_addr, out_ctrl  output  1/RD_W/5  SHALL present the head entry's flag, address and control fields.
REQ-017 out_branch_taken  output  1  SHALL equal out_ctrl[4] AND out_zero.
REQ-018 out_count  output  2  SHALL report the number of entries held: 0, 1 or 2.

Function
REQ-019 Storage SHALL be two registered entries, head and skid; states EMPTY, ONE, FULL.
REQ-020 A push SHALL occur when in_valid AND in_ready; a pop SHALL occur when out_valid AND out_ready.
REQ-021 in_ready SHALL be a registered signal, 1 exactly when the state is not FULL.
REQ-022 out_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-023 EMPTY + push SHALL load head and go to ONE; data SHALL appear on outputs the next cycle (latency 1).
REQ-024 ONE + push, no pop SHALL load skid and go to FULL.
REQ-025 ONE + push + pop SHALL load head with the incoming entry and stay in ONE.
REQ-026 ONE + pop, no push SHALL go to EMPTY.
REQ-027 FULL + pop SHALL move skid into head and go to ONE; a push is impossible because in_ready=0.
REQ-028 No state change SHALL occur without a push or pop; head fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Entries SHALL leave in strict arrival order; no entry SHALL be dropped or duplicated absent flush or reset.
REQ-030 flush SHALL have priority over push and pop: the next state SHALL be EMPTY and any same-cycle push SHALL be discarded.
REQ-031 After flush, in_ready SHALL be 1 on the next cycle.
REQ-032 out_ctrl and out_branch_taken SHALL be forced to 0 whenever out_valid=0, so bubbles never write registers or memory.
REQ-033 Data fields SHALL pass through bit-exact, with no arithmetic or width change.

Reset
REQ-034 While reset_n=0, the state SHALL be EMPTY and in_ready, out_valid, out_count, and all out_* data and control outputs SHALL be 0.
REQ-035 Reset assertion mid-transfer SHALL immediately discard both entries, independent of clk.
REQ-036 in_ready SHALL rise to 1 on the first clk edge after reset_n deasserts.

Verification
REQ-037 Reset then push {alu_result=0x0000_0000_0000_00FF, ctrl=0x01}, out_ready=1 -> one cycle later out_valid=1, out_alu_result=0xFF, out_count=1; next cycle out_valid=0, out_ctrl=0.
REQ-038 out_ready=0, push A=0x11 then B=0x22 -> out_count=2, in_ready=0, out_alu_result stays 0x11; raise out_ready -> 0x11 then 0x22 on consecutive cycles.
REQ-039 Continuous push every cycle with out_ready=1, values 1..8 -> outputs 1..8 with no gaps, out_count=1 throughout, in_ready=1 throughout.
REQ-040 FULL (0x33, 0x44) and flush=1 together with in_valid=1, data 0x55 -> next cycle out_valid=0, out_count=0, and 0x55 never appears.
REQ-041 alu_zero=1 with ctrl_in[4]=1 -> out_branch_taken=1 while valid; the same entry with alu_zero=0 -> out_branch_taken=0.
REQ-042 reset_n pulsed low between clk edges while FULL -> out_valid=0 and in_ready=0 immediately; in_ready=1 after the first edge following release.
